// File: rtl/pack_s3_stream.sv
// Streaming S3 packer: one ternary coefficient in per beat, five trits out per byte (base 3).
// Latency: a byte reaches out_byte/out_valid one cycle after its last trit is accepted (empty FIFO).
// Backpressure: in_ready drops while the output FIFO is full; out_valid follows FIFO occupancy.
//
// Ports: clk/rst (synchronous, active-high); start begins a frame in IDLE;
//   in_valid/in_ready/in_trit = trit input stream (00=0, 01=1, 10=2, 11=illegal);
//   out_valid/out_ready/out_byte/out_last = packed byte stream from the FIFO head;
//   busy = frame in progress, done = one-cycle pulse after the final byte pops,
//   err = sticky illegal-trit flag.
// Optional feature macro: PACK_S3_CHECK_EN (builds the illegal-trit check; otherwise err is tied 0).
module pack_s3_stream #(
    parameter int N_TRITS    = 700,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_trit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] trit_cnt;
    logic [2:0]    grp_idx;
    logic [7:0]    acc;

    // FIFO entry: {last flag, byte}
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          fifo_full;

    logic          accept;
    logic          pop;
    logic          push;
    logic          last_trit;
    logic [1:0]    trit_val;
    logic [7:0]    weight;
    logic [7:0]    term;
    logic [7:0]    packed_byte;
    logic [8:0]    head;

    assign fifo_full = (occ == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (occ != '0);
    assign head      = mem[rd_ptr];
    assign out_byte  = head[7:0];
    assign out_last  = out_valid & head[8];

    assign in_ready  = (state == PACK) & ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign last_trit = (trit_cnt == CW'(N_TRITS - 1));
    assign push      = accept & ((grp_idx == 3'd4) | last_trit);

    // Illegal code 11 contributes nothing to the byte.
    assign trit_val  = (in_trit == 2'b11) ? 2'b00 : in_trit;

    always_comb begin
        weight = 8'd1;
        case (grp_idx)
            3'd0:    weight = 8'd1;
            3'd1:    weight = 8'd3;
            3'd2:    weight = 8'd9;
            3'd3:    weight = 8'd27;
            default: weight = 8'd81;
        endcase
    end

    // Trit 2 doubles the weight; the group maximum 242 still fits in 8 bits.
    assign term        = trit_val[1] ? (weight << 1) : (trit_val[0] ? weight : 8'd0);
    assign packed_byte = acc + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            trit_cnt <= '0;
            grp_idx  <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PACK;
                        busy     <= 1'b1;
                        trit_cnt <= '0;
                        grp_idx  <= '0;
                        acc      <= '0;
                    end
                end
                PACK: begin
                    if (accept) begin
                        trit_cnt <= trit_cnt + CW'(1);
                        if (last_trit)
                            state <= DRAIN;
                        if (push) begin
                            acc     <= '0;
                            grp_idx <= '0;
                        end else begin
                            acc     <= packed_byte;
                            grp_idx <= grp_idx + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    // The flagged entry is the final byte of the frame.
                    if (pop && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {last_trit, packed_byte};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef PACK_S3_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && start)
            err <= 1'b0;
        else if (accept && in_trit == 2'b11)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pack_s3_stream.sv
// Bench for pack_s3_stream: three instances (N_TRITS = 5, 7, 700; FIFO_DEPTH = 4) on one clock.
// Inputs are driven and outputs sampled at the falling edge; handshakes complete at the next rising edge.
// Directed frames carry hand-computed bytes; random frames use a base-3 reference sum.
module tb_pack_s3_stream;
    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] start;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [1:0] in_trit [3];
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic [7:0] out_byte [3];
    logic [2:0] out_last;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] err;

    int nvec = 0;
    int nbad = 0;
    int tq [$];
    int eq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pack_s3_stream #(
            .N_TRITS   ((g == 0) ? 5 : (g == 1) ? 7 : 700),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_trit  (in_trit[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_byte (out_byte[g]),
            .out_last (out_last[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .err      (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: byte b = sum over j of t[5b+j] * 3^j, missing or illegal trits count 0.
    task automatic model_bytes(input int n);
        eq.delete();
        for (int b = 0; b < (n + 4) / 5; b++) begin
            int v = 0;
            int p = 1;
            for (int j = 0; j < 5; j++) begin
                int idx = b * 5 + j;
                int t = (idx < n && tq[idx] != 3) ? tq[idx] : 0;
                v += t * p;
                p *= 3;
            end
            eq.push_back(v);
        end
    endtask

    task automatic rand_trits(input int n);
        tq.delete();
        for (int i = 0; i < n; i++)
            tq.push_back(int'($urandom_range(0, 2)));
    endtask

    // Runs one frame on instance k; consumer stalls for the first 'stall' cycles.
    task automatic run_frame(input int k, input int n, input int stall, input string nm);
        int ti = 0;
        int bi = 0;
        int nb = (n + 4) / 5;
        int cyc = 0;
        int dn = 0;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        check({nm, "_busy_start"}, busy[k], 1);
        check({nm, "_err_cleared"}, err[k], 0);
        while (bi < nb && cyc < 20000) begin
            out_ready[k] = (cyc >= stall);
            in_valid[k]  = (ti < n);
            in_trit[k]   = (ti < n) ? tq[ti][1:0] : 2'b00;
            if (stall > 0 && cyc == stall) begin
                check({nm, "_stall_trits"}, ti, 20);
                check({nm, "_stall_in_ready"}, in_ready[k], 0);
                check({nm, "_stall_out_valid"}, out_valid[k], 1);
            end
            if (done[k]) dn++;
            if (in_valid[k] && in_ready[k]) ti++;
            if (out_valid[k] && out_ready[k]) begin
                check($sformatf("%s_byte%0d", nm, bi), out_byte[k], eq[bi]);
                check($sformatf("%s_last%0d", nm, bi), out_last[k], (bi == nb - 1) ? 1 : 0);
                bi++;
            end
            cyc++;
            @(negedge clk);
        end
        check({nm, "_bytes_seen"}, bi, nb);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done[k]) dn++;
            @(negedge clk);
        end
        check({nm, "_done_count"}, dn, 1);
        check({nm, "_idle_after"}, busy[k], 0);
        check({nm, "_trits_taken"}, ti, n);
    endtask

    initial begin
        int cnt;
        int guard;
        int dn;
        rst       = 3'b111;
        start     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_trit[k] = 2'b00;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_in_ready", k), in_ready[k], 0);
            check($sformatf("rst%0d_out_valid", k), out_valid[k], 0);
            check($sformatf("rst%0d_out_last", k), out_last[k], 0);
            check($sformatf("rst%0d_busy", k), busy[k], 0);
            check($sformatf("rst%0d_done", k), done[k], 0);
            check($sformatf("rst%0d_err", k), err[k], 0);
            check($sformatf("rst%0d_out_byte", k), out_byte[k], 0);
        end
        rst = 3'b000;

        // 1 + 2*3 + 0*9 + 1*27 + 2*81 = 196
        tq = '{1, 2, 0, 1, 2}; eq = '{8'hC4};
        run_frame(0, 5, 0, "t1");

        tq = '{2, 2, 2, 2, 2}; eq = '{8'hF2};
        run_frame(0, 5, 0, "t2_twos");

        // Illegal code in slot 0 packs as 0: 0 + 1*3 = 3
        tq = '{3, 1, 0, 0, 0}; eq = '{8'h03};
        run_frame(0, 5, 0, "ill");
`ifdef PACK_S3_CHECK_EN
        check("ill_err_set", err[0], 1);
`else
        check("ill_err_tied", err[0], 0);
`endif

        tq = '{0, 0, 0, 0, 0}; eq = '{8'h00};
        run_frame(0, 5, 0, "t2_zeros");

        // 1+3+9+27+81 = 121 = 0x79; then 2 + 1*3 = 5 padded
        tq = '{1, 1, 1, 1, 1, 2, 1}; eq = '{8'h79, 8'h05};
        run_frame(1, 7, 0, "t4");

        rand_trits(700); model_bytes(700);
        run_frame(2, 700, 0, "t3");

        rand_trits(700); model_bytes(700);
        run_frame(2, 700, 40, "t5");

        // Abort after 13 trits.
        @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        start[2]     = 1'b0;
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_trit[2]   = 2'b01;
        cnt = 0;
        guard = 0;
        while (cnt < 13 && guard < 100) begin
            if (in_ready[2]) cnt++;
            guard++;
            if (cnt < 13) @(negedge clk);
        end
        check("t6_trits_before_rst", cnt, 13);
        @(negedge clk);
        in_valid[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("t6_out_valid", out_valid[2], 0);
        check("t6_busy", busy[2], 0);
        check("t6_in_ready", in_ready[2], 0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (done[2]) dn++;
            @(negedge clk);
        end
        check("t6_no_done", dn, 0);

        rand_trits(700); model_bytes(700);
        run_frame(2, 700, 0, "t6_clean");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
